// File: rtl/wishbone_slave_xactor_if.sv
// Wishbone B4 pipelined bus plus client request/response port.
// The slave modport is the responder's view; master is the environment driving it.
interface wishbone_slave_xactor_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int REQ_WIDTH = 1 + SEL_WIDTH + ADDR_WIDTH + DATA_WIDTH;

   logic                  CYC_I;
   logic                  STB_I;
   logic                  WE_I;
   logic [ADDR_WIDTH-1:0] ADR_I;
   logic [SEL_WIDTH-1:0]  SEL_I;
   logic [DATA_WIDTH-1:0] DAT_I;
   logic                  STALL_O;
   logic                  ACK_O;
   logic [DATA_WIDTH-1:0] DAT_O;
   logic                  req_valid;
   logic                  req_ready;
   logic [REQ_WIDTH-1:0]  req_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      output STALL_O, ACK_O, DAT_O,
      output req_valid, req_data,
      input  req_ready,
      input  rsp_valid, rsp_data,
      output rsp_ready
   );

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      input  STALL_O, ACK_O, DAT_O,
      input  req_valid, req_data,
      output req_ready,
      output rsp_valid, rsp_data,
      input  rsp_ready
   );
endinterface

// File: rtl/wishbone_slave_xactor.sv
// Wishbone B4 pipelined slave: queues bus requests to a client and returns
// client responses as ACK beats; a dropped CYC flushes the queue and drains.
module wishbone_slave_xactor #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int REQ_DEPTH       = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   wishbone_slave_xactor_if.slave  bus
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int PW = $clog2(REQ_DEPTH);
   localparam int FW = $clog2(REQ_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   typedef struct packed {
      logic                  we;
      logic [SEL_WIDTH-1:0]  sel;
      logic [ADDR_WIDTH-1:0] adr;
      logic [DATA_WIDTH-1:0] dat;
   } req_t;

   logic [1:0]            state, state_nxt;
   req_t                  mem [REQ_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [FW-1:0]         fifo_cnt, fifo_nxt;
   logic [OW-1:0]         inflight, inflight_nxt, outstanding;
   logic                  stall, req_vld, rsp_rdy;
   logic                  accept, pop, rsp_take, flush, ack_now;
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] dat_q;

   // Stall and client handshakes depend only on registered state.
   assign outstanding = OW'(fifo_cnt) + inflight;
   assign stall    = (fifo_cnt == FW'(REQ_DEPTH)) |
                     (outstanding == OW'(MAX_OUTSTANDING)) |
                     (state == S_DRAIN);
   assign req_vld  = (fifo_cnt != '0) && (state != S_DRAIN);
   assign rsp_rdy  = (inflight != '0) && ((state == S_ACTIVE) || (state == S_DRAIN));

   assign accept   = bus.CYC_I & bus.STB_I & ~stall;
   assign pop      = req_vld & bus.req_ready;
   assign rsp_take = rsp_rdy & bus.rsp_valid;
   assign flush    = (state == S_ACTIVE) && !bus.CYC_I;
   assign ack_now  = rsp_take && (state == S_ACTIVE);

   always_comb begin
      fifo_nxt     = fifo_cnt + FW'(accept) - FW'(pop);
      inflight_nxt = inflight + OW'(pop) - OW'(rsp_take);
      if (flush) fifo_nxt = '0;
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.CYC_I) state_nxt = S_ACTIVE;
         S_ACTIVE: if (!bus.CYC_I) state_nxt = (inflight_nxt == '0) ? S_IDLE : S_DRAIN;
         S_DRAIN:  if (inflight_nxt == '0) state_nxt = bus.CYC_I ? S_ACTIVE : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         fifo_cnt <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state    <= state_nxt;
         fifo_cnt <= fifo_nxt;
         inflight <= inflight_nxt;
         // Flush empties the queue by catching the read pointer up.
         if (flush) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
         end
         ack_q <= ack_now;
         dat_q <= ack_now ? bus.rsp_data : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) mem[wr_ptr] <= req_t'({bus.WE_I, bus.SEL_I, bus.ADR_I, bus.DAT_I});
   end

   assign bus.STALL_O   = stall;
   assign bus.ACK_O     = ack_q;
   assign bus.DAT_O     = dat_q;
   assign bus.req_valid = req_vld;
   assign bus.req_data  = mem[rd_ptr];
   assign bus.rsp_ready = rsp_rdy;
endmodule

// File: tb/tb_wishbone_slave_xactor.sv
// Directed and randomized bench for wishbone_slave_xactor against a queue-based model.
module tb_wishbone_slave_xactor;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int RD = 2;
   localparam int MO = 8;
   localparam int RW = 1 + SW + AW + DW;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   wishbone_slave_xactor_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   wishbone_slave_xactor #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(RD), .MAX_OUTSTANDING(MO)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus)
   );

   // Model: queued requests, count held by the client, drain flag, pending ACK.
   logic [RW-1:0] m_fifo[$];
   int            m_inflight;
   bit            m_drain;
   bit            m_ack;
   logic [DW-1:0] m_dat;
   int            npass = 0;
   int            ntot = 0;
   int            acks;
   logic [RW-1:0] exp_w;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      ntot++;
      assert (got === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_clear();
      m_fifo.delete();
      m_inflight = 0;
      m_drain = 0;
      m_ack = 0;
      m_dat = '0;
   endtask

   task automatic bus_quiet();
      bus.CYC_I = 0; bus.STB_I = 0; bus.WE_I = 0; bus.ADR_I = '0;
      bus.SEL_I = '0; bus.DAT_I = '0; bus.req_ready = 0;
      bus.rsp_valid = 0; bus.rsp_data = '0;
   endtask

   // Check outputs against the model, advance the model over the next edge.
   task automatic cycle();
      bit stall, rv, rr, acc, pop, rsp;
      stall = (m_fifo.size() == RD) || (m_fifo.size() + m_inflight == MO) || m_drain;
      rv = (m_fifo.size() > 0) && !m_drain;
      rr = m_inflight > 0;
      chk("stall", bus.STALL_O, stall);
      chk("req_valid", bus.req_valid, rv);
      chk("rsp_ready", bus.rsp_ready, rr);
      chk("ack", bus.ACK_O, m_ack);
      if (m_ack) chk("dat_o", bus.DAT_O, m_dat);
      if (rv) chk("req_data", bus.req_data, m_fifo[0]);
      acc = bus.CYC_I && bus.STB_I && !stall;
      pop = rv && bus.req_ready;
      rsp = rr && bus.rsp_valid;
      if (RST_N) begin
         m_ack = 0;
         if (!m_drain) begin
            if (rsp) begin m_ack = 1; m_dat = bus.rsp_data; m_inflight--; end
            if (pop) begin void'(m_fifo.pop_front()); m_inflight++; end
            if (acc) m_fifo.push_back({bus.WE_I, bus.SEL_I, bus.ADR_I, bus.DAT_I});
            if (!bus.CYC_I) begin m_fifo.delete(); m_drain = (m_inflight > 0); end
         end else begin
            if (rsp) m_inflight--;
            if (m_inflight == 0) m_drain = 0;
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      #2 RST_N = 0;
      #1;
      model_clear();
      chk("rst_stall", bus.STALL_O, 0);
      chk("rst_ack", bus.ACK_O, 0);
      chk("rst_dat", bus.DAT_O, 0);
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_rsp_ready", bus.rsp_ready, 0);
      @(negedge CLK);
      cycle();
      RST_N = 1;
   endtask

   initial begin
      bus_quiet();
      model_clear();
      @(negedge CLK);
      do_reset();
      cycle();

      // Single read of 0x100 answered one cycle after the pop.
      bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 0; bus.ADR_I = 32'h100; bus.SEL_I = 4'hF;
      cycle();
      bus.STB_I = 0; bus.req_ready = 1;
      cycle();
      bus.req_ready = 0; bus.rsp_valid = 1; bus.rsp_data = 32'hDEADBEEF;
      cycle();
      bus.rsp_valid = 0;
      chk("read_ack", bus.ACK_O, 1);
      chk("read_dat", bus.DAT_O, 32'hDEADBEEF);
      cycle();
      bus.CYC_I = 0;
      cycle();
      cycle();

      // Single write, request word checked against the literal layout.
      bus.CYC_I = 1; bus.STB_I = 1; bus.WE_I = 1; bus.ADR_I = 32'h200;
      bus.SEL_I = 4'hF; bus.DAT_I = 32'h12345678;
      cycle();
      exp_w = {1'b1, 4'hF, 32'h200, 32'h12345678};
      chk("write_req_data", bus.req_data, exp_w);
      bus.STB_I = 0; bus.req_ready = 1;
      cycle();
      bus.req_ready = 0; bus.rsp_valid = 1; bus.rsp_data = $urandom;
      cycle();
      bus.rsp_valid = 0;
      cycle();

      // Burst of 8 reads with a zero-latency client.
      bus.WE_I = 0; bus.req_ready = 1; bus.rsp_valid = 1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         bus.STB_I = 1; bus.ADR_I = 32'h1000 + 4 * i; bus.rsp_data = $urandom;
         cycle();
         acks += int'(bus.ACK_O);
      end
      bus.STB_I = 0;
      for (int i = 0; i < 6; i++) begin
         bus.rsp_data = $urandom;
         cycle();
         acks += int'(bus.ACK_O);
      end
      chk("burst_acks", acks, 8);
      bus.rsp_valid = 0; bus.req_ready = 0;

      // Back-pressure: client not ready, third strobe stalls.
      bus.STB_I = 1;
      for (int i = 0; i < 3; i++) begin
         bus.ADR_I = $urandom; bus.DAT_I = $urandom;
         cycle();
      end
      chk("bp_stall", bus.STALL_O, 1);
      bus.req_ready = 1;
      // Fill to the outstanding limit with no responses.
      for (int i = 0; i < 10; i++) begin
         bus.ADR_I = $urandom;
         cycle();
      end
      chk("max_stall", bus.STALL_O, 1);
      bus.STB_I = 0; bus.rsp_valid = 1; bus.rsp_data = $urandom;
      cycle();
      bus.rsp_valid = 0;
      chk("max_release", bus.STALL_O, 0);
      bus.rsp_valid = 1;
      for (int i = 0; i < 10; i++) begin
         bus.rsp_data = $urandom;
         cycle();
      end
      bus.rsp_valid = 0; bus.req_ready = 0;
      cycle();

      // Abort: two popped, one queued, then CYC dropped.
      bus.STB_I = 1; bus.req_ready = 1;
      for (int i = 0; i < 3; i++) begin
         bus.ADR_I = $urandom;
         cycle();
      end
      bus.STB_I = 0; bus.req_ready = 0;
      cycle();
      bus.CYC_I = 0;
      cycle();
      chk("drain_stall", bus.STALL_O, 1);
      bus.rsp_valid = 1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         bus.rsp_data = $urandom;
         cycle();
         acks += int'(bus.ACK_O);
      end
      chk("drain_acks", acks, 0);
      bus.rsp_valid = 0;
      chk("post_drain_stall", bus.STALL_O, 0);
      bus.CYC_I = 1; bus.STB_I = 1; bus.ADR_I = 32'h300;
      cycle();
      bus.STB_I = 0; bus.req_ready = 1;
      cycle();
      bus.req_ready = 0; bus.rsp_valid = 1; bus.rsp_data = $urandom;
      cycle();
      bus.rsp_valid = 0;
      cycle();

      // Reset with four outstanding.
      bus.STB_I = 1; bus.req_ready = 1;
      for (int i = 0; i < 4; i++) begin
         bus.ADR_I = $urandom;
         cycle();
      end
      bus.STB_I = 0; bus.req_ready = 0;
      do_reset();
      bus_quiet();
      cycle();
      chk("post_rst_stall", bus.STALL_O, 0);

      // Randomized traffic with occasional aborts.
      for (int i = 0; i < 600; i++) begin
         bus.CYC_I = ($urandom_range(0, 24) != 0);
         bus.STB_I = $urandom;
         bus.WE_I = $urandom;
         bus.ADR_I = $urandom;
         bus.SEL_I = $urandom;
         bus.DAT_I = $urandom;
         bus.req_ready = $urandom;
         bus.rsp_valid = $urandom;
         bus.rsp_data = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
